stim: RTL and testbench

// Stimulus sequencer upstream of the checker. Walks a test program in SRAM through an Avalon-MM read master.

---
 rtl/stim_pkg.sv | 30 +++
 rtl/stim_if.sv | 34 +++
 rtl/stim_rd_master.sv | 48 ++++
 rtl/stim.sv | 117 +++++++++++
 tb/tb_stim.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stim_pkg.sv
// Shared definitions for the stimulus sequencer: widths, checker command codes,
// program record types and state encodings.
package stim_pkg;
  localparam int ADDR_WIDTH          = 20;
  localparam int DATA_WIDTH          = 16;
  localparam int STF_WIDTH           = 24;
  localparam int RTF_WIDTH           = 24;
  localparam int CHF_WIDTH           = RTF_WIDTH + ADDR_WIDTH;
  localparam int SCC_WIDTH           = 5;
  localparam int SCD_WIDTH           = 24;
  localparam int RESULT_VECTOR_WORDS = 2;

  localparam logic [SCC_WIDTH-1:0] SC_CMD_IDLE    = SCC_WIDTH'(0);
  localparam logic [SCC_WIDTH-1:0] SC_CMD_BITMASK = SCC_WIDTH'(1);

  localparam logic [7:0] TYPE_END    = 8'h00;
  localparam logic [7:0] TYPE_VECTOR = 8'h01;
  localparam logic [7:0] TYPE_MASK   = 8'h02;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH_HDR, S_DECODE, S_FETCH, S_PUSH,
    S_DRAIN_MASK, S_SET_MASK, S_DRAIN_END, S_DONE
  } state_t;

  typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_WAIT} rd_state_t;

  function automatic logic [ADDR_WIDTH-1:0] next_res_addr(input logic [ADDR_WIDTH-1:0] a);
    return a + ADDR_WIDTH'(RESULT_VECTOR_WORDS);
  endfunction
endpackage

// File: rtl/stim_if.sv
// Bus bundle between the sequencer and its neighbours: Avalon-MM read port,
// the two FIFO write ports and the checker command link.
interface stim_if;
  import stim_pkg::*;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] mem_readdata;
  logic                  mem_readdatavalid;
  logic                  mem_waitrequest;
  logic [STF_WIDTH-1:0]  sfifo_data;
  logic                  sfifo_wrreq;
  logic                  sfifo_wrfull;
  logic [CHF_WIDTH-1:0]  cfifo_data;
  logic                  cfifo_wrreq;
  logic                  cfifo_wrfull;
  logic [SCC_WIDTH-1:0]  sc_cmd;
  logic [SCD_WIDTH-1:0]  sc_data;
  logic                  sc_ready;

  modport master (
    output mem_address, mem_read, sfifo_data, sfifo_wrreq,
           cfifo_data, cfifo_wrreq, sc_cmd, sc_data,
    input  mem_readdata, mem_readdatavalid, mem_waitrequest,
           sfifo_wrfull, cfifo_wrfull, sc_ready
  );

  modport slave (
    input  mem_address, mem_read, sfifo_data, sfifo_wrreq,
           cfifo_data, cfifo_wrreq, sc_cmd, sc_data,
    output mem_readdata, mem_readdatavalid, mem_waitrequest,
           sfifo_wrfull, cfifo_wrfull, sc_ready
  );
endinterface

// File: rtl/stim_rd_master.sv
// Single-outstanding Avalon-MM read master: a req pulse while idle issues one
// read at addr; the returned word is presented with word_vld for one cycle.
module stim_rd_master
  import stim_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_readdatavalid,
  input  logic                  mem_waitrequest,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_vld,
  output logic                  accept,
  output logic                  idle
);
  rd_state_t state, state_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RD_IDLE;
      mem_address <= '0;
    end else begin
      state <= state_nxt;
      if (state == RD_IDLE && req) mem_address <= addr;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RD_IDLE: if (req)                state_nxt = RD_REQ;
      RD_REQ:  if (!mem_waitrequest)   state_nxt = RD_WAIT;
      RD_WAIT: if (mem_readdatavalid)  state_nxt = RD_IDLE;
      default:                         state_nxt = RD_IDLE;
    endcase
  end

  // Read data is only meaningful while a read is outstanding
  assign mem_read = (state == RD_REQ);
  assign accept   = mem_read && !mem_waitrequest;
  assign word_vld = (state == RD_WAIT) && mem_readdatavalid;
  assign word     = mem_readdata;
  assign idle     = (state == RD_IDLE);
endmodule

// File: rtl/stim.sv
// Stimulus sequencer: walks a test program in memory, pushes vectors into the
// stimulus/check FIFO pair and forwards bitmask records to the checker.
module stim
  import stim_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] prog_base,
  input  logic [ADDR_WIDTH-1:0] res_base,
  output logic                  busy,
  output logic                  done,
  stim_if.master                bus
);
  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr, res_addr;
  logic [7:0]            hdr_type;
  logic                  rec_vec;
  logic [1:0]            wcnt;
  logic [DATA_WIDTH-1:0] w1, w2, w3;
  logic                  rd_req, rd_accept, rd_idle, word_vld, push, last_word;
  logic [DATA_WIDTH-1:0] word;

  stim_rd_master u_rd (
    .clock             (clock),
    .reset             (reset),
    .req               (rd_req),
    .addr              (rd_addr),
    .mem_address       (bus.mem_address),
    .mem_read          (bus.mem_read),
    .mem_readdata      (bus.mem_readdata),
    .mem_readdatavalid (bus.mem_readdatavalid),
    .mem_waitrequest   (bus.mem_waitrequest),
    .word              (word),
    .word_vld          (word_vld),
    .accept            (rd_accept),
    .idle              (rd_idle)
  );

  assign last_word = (wcnt == (rec_vec ? 2'd2 : 2'd1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      rd_addr  <= '0;
      res_addr <= '0;
      hdr_type <= TYPE_END;
      rec_vec  <= 1'b0;
      wcnt     <= '0;
      w1       <= '0;
      w2       <= '0;
      w3       <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        rd_addr  <= prog_base;
        res_addr <= res_base;
      end else if (rd_accept) begin
        rd_addr <= rd_addr + ADDR_WIDTH'(1);
      end
      if (state == S_FETCH_HDR && word_vld) hdr_type <= word[15:8];
      if (state == S_DECODE) begin
        rec_vec <= (hdr_type == TYPE_VECTOR);
        wcnt    <= '0;
      end
      if (state == S_FETCH && word_vld) begin
        case (wcnt)
          2'd0:    w1 <= word;
          2'd1:    w2 <= word;
          default: w3 <= word;
        endcase
        wcnt <= wcnt + 2'd1;
      end
      if (push) res_addr <= next_res_addr(res_addr);
    end
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    push      = 1'b0;
    case (state)
      S_IDLE:      if (start) state_nxt = S_FETCH_HDR;
      S_FETCH_HDR: begin
        rd_req = rd_idle;
        if (word_vld) state_nxt = S_DECODE;
      end
      S_DECODE:
        if (hdr_type == TYPE_VECTOR || hdr_type == TYPE_MASK) state_nxt = S_FETCH;
        else                                                  state_nxt = S_DRAIN_END;
      S_FETCH: begin
        rd_req = rd_idle;
        if (word_vld && last_word) state_nxt = rec_vec ? S_PUSH : S_DRAIN_MASK;
      end
      // Both FIFOs are written together so their occupancies never diverge
      S_PUSH:
        if (!bus.sfifo_wrfull && !bus.cfifo_wrfull) begin
          push      = 1'b1;
          state_nxt = S_FETCH_HDR;
        end
      S_DRAIN_MASK: if (bus.sc_ready) state_nxt = S_SET_MASK;
      S_SET_MASK:   state_nxt = S_FETCH_HDR;
      S_DRAIN_END:  if (bus.sc_ready) state_nxt = S_DONE;
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  assign bus.sfifo_wrreq = push;
  assign bus.cfifo_wrreq = push;
  assign bus.sfifo_data  = {w1, w2[15:8]};
  assign bus.cfifo_data  = {w2[7:0], w3, res_addr};
  assign bus.sc_cmd      = (state == S_SET_MASK) ? SC_CMD_BITMASK : SC_CMD_IDLE;
  assign bus.sc_data     = (state == S_SET_MASK) ? {w1, w2[15:8]} : '0;
  assign busy            = (state != S_IDLE) && (state != S_DONE);
  assign done            = (state == S_DONE);
endmodule

// File: tb/tb_stim.sv
// Bench for the stimulus sequencer: memory responder, program-parsing model and
// a per-cycle compare process, driven by directed programs.
module tb_stim;
  import stim_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [ADDR_WIDTH-1:0] prog_base = '0;
  logic [ADDR_WIDTH-1:0] res_base = '0;
  logic                  busy, done;

  stim_if bus();

  stim dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .prog_base (prog_base),
    .res_base  (res_base),
    .busy      (busy),
    .done      (done),
    .bus       (bus.master)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] mem [0:255];
  logic [STF_WIDTH-1:0] exp_s[$];
  logic [CHF_WIDTH-1:0] exp_c[$];
  logic [SCD_WIDTH-1:0] exp_m[$];
  int                   exp_mpre[$];
  logic [CHF_WIDTH-1:0] c_log[$];
  logic [STF_WIDTH-1:0] last_s = '0;
  logic [SCD_WIDTH-1:0] last_mask = '0;
  int wr_cnt = 0, mask_cnt = 0, done_cnt = 0;
  int ws_cfg = 0, lat_cfg = 1, ws_left = 0, lat_left = 0;
  bit in_req = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Avalon slave: programmable waitrequest stall and read latency
  initial begin
    logic                  acc;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [7:0]            pend;
    pend = '0;
    bus.mem_readdata = '0;
    bus.mem_readdatavalid = 1'b0;
    bus.mem_waitrequest = 1'b0;
    forever begin
      @(posedge clock);
      acc = bus.mem_read && !bus.mem_waitrequest;
      acc_addr = bus.mem_address;
      #1;
      bus.mem_readdatavalid = 1'b0;
      if (reset) begin
        in_req = 1'b0;
        lat_left = 0;
        bus.mem_waitrequest = 1'b0;
      end else begin
        if (lat_left > 0) begin
          lat_left--;
          if (lat_left == 0) begin
            bus.mem_readdata = mem[pend];
            bus.mem_readdatavalid = 1'b1;
          end
        end
        if (acc) begin
          in_req = 1'b0;
          pend = acc_addr[7:0];
          lat_left = lat_cfg;
        end
        if (bus.mem_read && !in_req) begin
          in_req = 1'b1;
          ws_left = ws_cfg;
        end
        if (in_req && ws_left > 0) begin
          bus.mem_waitrequest = 1'b1;
          ws_left--;
        end else begin
          bus.mem_waitrequest = 1'b0;
        end
      end
    end
  end

  // Model: parse the program and list the FIFO writes and masks it must produce
  task automatic build_model(input logic [7:0] pb, input logic [ADDR_WIDTH-1:0] rb);
    logic [7:0] a;
    logic [ADDR_WIDTH-1:0] r;
    logic [15:0] h, x1, x2, x3;
    int nv;
    a = pb; r = rb; nv = 0;
    exp_s.delete(); exp_c.delete(); exp_m.delete(); exp_mpre.delete();
    for (int k = 0; k < 32; k++) begin
      h = mem[a]; x1 = mem[a + 8'd1]; x2 = mem[a + 8'd2]; x3 = mem[a + 8'd3];
      if (h[15:8] == 8'h01) begin
        exp_s.push_back({x1, x2[15:8]});
        exp_c.push_back({x2[7:0], x3, r});
        r = r + ADDR_WIDTH'(2);
        nv++;
        a = a + 8'd4;
      end else if (h[15:8] == 8'h02) begin
        exp_m.push_back({x1, x2[15:8]});
        exp_mpre.push_back(nv);
        a = a + 8'd3;
      end else begin
        break;
      end
    end
  endtask

  task automatic monitor();
    logic pr, pw, prdy;
    logic [ADDR_WIDTH-1:0] pa;
    logic [SCC_WIDTH-1:0] pc;
    pr = 0; pw = 0; prdy = 0; pa = '0; pc = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pr = 0; pw = 0; prdy = 0; pc = '0;
      end else begin
        if (pr && pw) chk("rd_hold", 64'({bus.mem_read, bus.mem_address}), 64'({1'b1, pa}));
        if (bus.mem_read) chk("rd_outstanding", 64'(lat_left), 64'(0));
        if (bus.sfifo_wrreq || bus.cfifo_wrreq) begin
          wr_cnt++;
          chk("wr_joint", 64'({bus.sfifo_wrreq, bus.cfifo_wrreq}), 64'(3));
          chk("wr_while_full", 64'({bus.sfifo_wrfull, bus.cfifo_wrfull}), 64'(0));
          last_s = bus.sfifo_data;
          c_log.push_back(bus.cfifo_data);
          if (exp_s.size() == 0) chk("wr_unexpected", 64'(wr_cnt), 64'(0));
          else begin
            chk("sfifo_data", 64'(bus.sfifo_data), 64'(exp_s.pop_front()));
            chk("cfifo_data", 64'(bus.cfifo_data), 64'(exp_c.pop_front()));
          end
        end
        if (bus.sc_cmd != SC_CMD_IDLE) begin
          mask_cnt++;
          last_mask = bus.sc_data;
          chk("sc_cmd", 64'(bus.sc_cmd), 64'(SC_CMD_BITMASK));
          chk("sc_ready_first", 64'(prdy), 64'(1));
          chk("sc_one_cycle", 64'(pc), 64'(0));
          if (exp_m.size() == 0) chk("mask_unexpected", 64'(mask_cnt), 64'(0));
          else begin
            chk("sc_data", 64'(bus.sc_data), 64'(exp_m.pop_front()));
            chk("mask_order", 64'(wr_cnt), 64'(exp_mpre.pop_front()));
          end
        end
        if (done) begin
          done_cnt++;
          chk("done_busy", 64'(busy), 64'(0));
          chk("done_after_ready", 64'(prdy), 64'(1));
          chk("done_pending", 64'(exp_s.size() + exp_m.size()), 64'(0));
        end
        pr = bus.mem_read; pw = bus.mem_waitrequest; pa = bus.mem_address;
        prdy = bus.sc_ready; pc = bus.sc_cmd;
      end
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctrl"}, 64'({busy, done, bus.mem_read, bus.sfifo_wrreq, bus.cfifo_wrreq, bus.sc_cmd}), 64'(0));
    chk({tag, "_addr"}, 64'(bus.mem_address), 64'(0));
    chk({tag, "_data"}, 64'({bus.sfifo_data, bus.sc_data}), 64'(0));
    chk({tag, "_cdata"}, 64'(bus.cfifo_data), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    #3 reset = 1'b1;
    #1 chk_quiet(tag);
    exp_s.delete(); exp_c.delete(); exp_m.delete(); exp_mpre.delete();
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic start_prog(input logic [ADDR_WIDTH-1:0] pb, input logic [ADDR_WIDTH-1:0] rb);
    build_model(pb[7:0], rb);
    wr_cnt = 0; mask_cnt = 0; c_log.delete();
    @(posedge clock); #1;
    prog_base = pb; res_base = rb; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    chk("done_seen", 64'(done_cnt - d0), 64'(1));
    if (done_cnt == d0) do_reset("timeout");
    @(negedge clock);
    chk("idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    int dc;
    fork
      monitor();
    join_none
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    // 0x00: single vector
    mem[8'h00] = 16'h0100; mem[8'h01] = 16'hABCD; mem[8'h02] = 16'hEF12; mem[8'h03] = 16'h3456;
    // 0x10: three vectors
    mem[8'h10] = 16'h0100; mem[8'h11] = 16'h1111; mem[8'h12] = 16'h2222; mem[8'h13] = 16'h3333;
    mem[8'h14] = 16'h0100; mem[8'h15] = 16'h4444; mem[8'h16] = 16'h5555; mem[8'h17] = 16'h6666;
    mem[8'h18] = 16'h0100; mem[8'h19] = 16'h7777; mem[8'h1A] = 16'h8888; mem[8'h1B] = 16'h9999;
    // 0x30: mask only
    mem[8'h30] = 16'h0200; mem[8'h31] = 16'h00FF; mem[8'h32] = 16'hFF00;
    // 0x40: vector, mask, vector, unknown type terminates
    mem[8'h40] = 16'h0100; mem[8'h41] = 16'hA1A2; mem[8'h42] = 16'hA3A4; mem[8'h43] = 16'hA5A6;
    mem[8'h44] = 16'h0200; mem[8'h45] = 16'h1234; mem[8'h46] = 16'h5677;
    mem[8'h47] = 16'h0100; mem[8'h48] = 16'hB1B2; mem[8'h49] = 16'hB3B4; mem[8'h4A] = 16'hB5B6;
    mem[8'h4B] = 16'h0700;
    bus.sfifo_wrfull = 1'b0; bus.cfifo_wrfull = 1'b0; bus.sc_ready = 1'b1;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_quiet("reset");
    @(posedge clock); #1 reset = 1'b0;

    // single vector; done withheld until checker reports ready
    bus.sc_ready = 1'b0;
    dc = done_cnt;
    start_prog(20'h00000, 20'h00400);
    repeat (40) @(posedge clock);
    chk("t1_no_done", 64'(done_cnt - dc), 64'(0));
    chk("t1_wr_cnt", 64'(wr_cnt), 64'(1));
    #1 bus.sc_ready = 1'b1;
    wait_done(200);
    chk("t1_sdata", 64'(last_s), 64'(24'hABCDEF));
    chk("t1_cdata", 64'(c_log[0]), 64'({24'h123456, 20'h00400}));

    // three vectors, result stride
    start_prog(20'h00010, 20'h00400);
    wait_done(400);
    chk("t2_wr_cnt", 64'(wr_cnt), 64'(3));
    chk("t2_addr0", 64'(c_log[0]), 64'({24'h223333, 20'h00400}));
    chk("t2_addr1", 64'(c_log[1]), 64'({24'h556666, 20'h00402}));
    chk("t2_addr2", 64'(c_log[2]), 64'({24'h889999, 20'h00404}));
    chk("t2_sdata", 64'(last_s), 64'(24'h777788));

    // result address wraps
    start_prog(20'h00010, 20'hFFFFE);
    wait_done(400);
    chk("t3_addr0", 64'(c_log[0]), 64'({24'h223333, 20'hFFFFE}));
    chk("t3_addr1", 64'(c_log[1]), 64'({24'h556666, 20'h00000}));
    chk("t3_addr2", 64'(c_log[2]), 64'({24'h889999, 20'h00002}));

    // CHECK_FIFO full blocks both writes
    bus.cfifo_wrfull = 1'b1;
    start_prog(20'h00000, 20'h00400);
    repeat (40) @(posedge clock);
    chk("t4_blocked", 64'(wr_cnt), 64'(0));
    #1 bus.cfifo_wrfull = 1'b0;
    wait_done(200);
    chk("t4_wr_cnt", 64'(wr_cnt), 64'(1));

    // mask waits for checker drain
    bus.sc_ready = 1'b0;
    start_prog(20'h00030, 20'h00000);
    repeat (40) @(posedge clock);
    chk("t5_mask_held", 64'(mask_cnt), 64'(0));
    #1 bus.sc_ready = 1'b1;
    wait_done(200);
    chk("t5_mask_cnt", 64'(mask_cnt), 64'(1));
    chk("t5_mask", 64'(last_mask), 64'(24'h00FFFF));

    // mixed program ended by an unknown record type
    start_prog(20'h00040, 20'h00100);
    wait_done(600);
    chk("t6_wr_cnt", 64'(wr_cnt), 64'(2));
    chk("t6_mask", 64'(last_mask), 64'(24'h123456));
    chk("t6_sdata", 64'(last_s), 64'(24'hB1B2B3));
    chk("t6_cdata", 64'(c_log[1]), 64'({24'hB4B5B6, 20'h00102}));

    // slave stalls and slow read data
    ws_cfg = 5; lat_cfg = 3;
    start_prog(20'h00000, 20'h00400);
    wait_done(800);
    chk("t7_sdata", 64'(last_s), 64'(24'hABCDEF));
    chk("t7_cdata", 64'(c_log[0]), 64'({24'h123456, 20'h00400}));
    ws_cfg = 0; lat_cfg = 1;

    // reset while stuck in PUSH
    bus.sfifo_wrfull = 1'b1;
    start_prog(20'h00000, 20'h00400);
    repeat (40) @(posedge clock);
    do_reset("rst_push");
    bus.sfifo_wrfull = 1'b0;
    repeat (20) @(posedge clock);
    chk("t8_no_wr", 64'(wr_cnt), 64'(0));
    start_prog(20'h00000, 20'h00400);
    wait_done(200);
    chk("t8_rerun", 64'(c_log[0]), 64'({24'h123456, 20'h00400}));

    // reset in the middle of fetching a vector
    start_prog(20'h00010, 20'h00400);
    repeat (10) @(posedge clock);
    do_reset("rst_fetch");
    repeat (20) @(posedge clock);
    chk("t9_no_wr", 64'(wr_cnt), 64'(0));
    start_prog(20'h00010, 20'h00400);
    wait_done(400);
    chk("t9_wr_cnt", 64'(wr_cnt), 64'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
